// File: rtl/system_frame_reader.sv
// Avalon-MM read master that streams a contiguous block of on-chip memory words
// out as an Avalon-ST source, using a small credit-checked FIFO to absorb read latency.
module system_frame_reader #(
   parameter int ADDR_W     = 11,
   parameter int DATA_W     = 32,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic [ADDR_W-1:0]   base_addr,
   input  logic [ADDR_W:0]     length,
   output logic                busy,
   output logic                done,
   output logic [ADDR_W-1:0]   mem_address,
   output logic                mem_chipselect,
   output logic                mem_write,
   output logic [DATA_W/8-1:0] mem_byteenable,
   output logic                mem_clken,
   input  logic [DATA_W-1:0]   mem_readdata,
   output logic [DATA_W-1:0]   out_data,
   output logic                out_valid,
   input  logic                out_ready,
   output logic                out_sop,
   output logic                out_eop
);

   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   state_t              state, state_next;
   logic                done_next;
   logic [ADDR_W-1:0]   base_q;
   logic [ADDR_W:0]     len_q;
   logic [ADDR_W:0]     issued;
   logic [ADDR_W:0]     pushed;
   logic                pending;

   logic [DATA_W-1:0]   data_mem [FIFO_DEPTH];
   logic [FIFO_DEPTH-1:0] sop_mem;
   logic [FIFO_DEPTH-1:0] eop_mem;
   logic [PTR_W-1:0]    rd_ptr;
   logic [PTR_W-1:0]    wr_ptr;
   logic [CNT_W-1:0]    fifo_count;

   logic                push;
   logic                pop;
   logic [CNT_W:0]      occupancy;
   logic                credit_ok;
   logic                issue;

   assign mem_write      = 1'b0;
   assign mem_byteenable = '1;
   assign mem_clken      = 1'b1;

   assign busy      = (state != IDLE);
   assign out_valid = (fifo_count != '0);
   assign out_data  = data_mem[rd_ptr];
   assign out_sop   = out_valid & sop_mem[rd_ptr];
   assign out_eop   = out_valid & eop_mem[rd_ptr];

   assign push = pending;
   assign pop  = out_valid & out_ready;

   // Buffered words plus reads still in the memory pipeline must never exceed
   // the FIFO size; a pop this cycle frees its credit immediately.
   assign occupancy = (CNT_W+1)'(fifo_count) + (CNT_W+1)'(mem_chipselect)
                    + (CNT_W+1)'(pending) - (CNT_W+1)'(pop);
   assign credit_ok = occupancy < (CNT_W+1)'(FIFO_DEPTH);
   assign issue     = (state == RUN) && (issued < len_q) && credit_ok;

   always_comb begin
      state_next = state;
      done_next  = 1'b0;
      unique case (state)
         IDLE: begin
            if (start) begin
               if (length == '0) done_next  = 1'b1;
               else              state_next = RUN;
            end
         end
         RUN: begin
            if (issued == len_q) state_next = DRAIN;
         end
         DRAIN: begin
            if (pop && out_eop) begin
               state_next = IDLE;
               done_next  = 1'b1;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         done  <= 1'b0;
      end else begin
         state <= state_next;
         done  <= done_next;
      end
   end

   // The first read is launched on the accepted start edge so chipselect is
   // already high in the cycle after start.
   always_ff @(posedge clk) begin
      if (reset) begin
         base_q         <= '0;
         len_q          <= '0;
         issued         <= '0;
         mem_address    <= '0;
         mem_chipselect <= 1'b0;
         pending        <= 1'b0;
      end else begin
         pending <= mem_chipselect;
         if (state == IDLE && start) begin
            base_q <= base_addr;
            len_q  <= length;
            if (length != '0) begin
               mem_address    <= base_addr;
               mem_chipselect <= 1'b1;
               issued         <= (ADDR_W+1)'(1);
            end else begin
               mem_chipselect <= 1'b0;
               issued         <= '0;
            end
         end else if (issue) begin
            mem_address    <= base_q + issued[ADDR_W-1:0];
            mem_chipselect <= 1'b1;
            issued         <= issued + (ADDR_W+1)'(1);
         end else begin
            mem_chipselect <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < FIFO_DEPTH; i++) data_mem[i] <= '0;
         sop_mem    <= '0;
         eop_mem    <= '0;
         rd_ptr     <= '0;
         wr_ptr     <= '0;
         fifo_count <= '0;
         pushed     <= '0;
      end else begin
         if (state == IDLE && start) pushed <= '0;
         if (push) begin
            data_mem[wr_ptr] <= mem_readdata;
            sop_mem[wr_ptr]  <= (pushed == '0);
            eop_mem[wr_ptr]  <= (pushed == len_q - (ADDR_W+1)'(1));
            wr_ptr           <= wr_ptr + PTR_W'(1);
            pushed           <= pushed + (ADDR_W+1)'(1);
         end
         if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   fifo_count <= fifo_count + CNT_W'(1);
            2'b01:   fifo_count <= fifo_count - CNT_W'(1);
            default: fifo_count <= fifo_count;
         endcase
      end
   end

endmodule
